// File: rtl/cache_fill_ctrl.sv
// Block-fill and write-through controller that shares one pipelined memory port
// between I-cache fills, D-cache fills and D-side stores.
module cache_fill_ctrl_chk (
    input  logic clk,
    input  logic rst,
    input  logic mem_en,
    input  logic mem_wr,
    input  logic fill_valid,
    input  logic i_fill_done,
    input  logic d_fill_done,
    input  logic wr_ack
);
    a_done_excl:  assert property (@(posedge clk) disable iff (!rst) !(i_fill_done && d_fill_done));
    a_i_pulse:    assert property (@(posedge clk) disable iff (!rst) i_fill_done |=> !i_fill_done);
    a_d_pulse:    assert property (@(posedge clk) disable iff (!rst) d_fill_done |=> !d_fill_done);
    a_ack_pulse:  assert property (@(posedge clk) disable iff (!rst) wr_ack |=> !wr_ack);
    a_ack_write:  assert property (@(posedge clk) disable iff (!rst) wr_ack |-> (mem_en && mem_wr));
    a_done_last:  assert property (@(posedge clk) disable iff (!rst) (i_fill_done || d_fill_done) |-> fill_valid);
    a_no_wr_fill: assert property (@(posedge clk) disable iff (!rst) fill_valid |-> !mem_wr);
endmodule

module cache_fill_ctrl #(
    parameter int AWIDTH          = 16,
    parameter int DWIDTH          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [AWIDTH-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [AWIDTH-1:0] d_miss_addr,
    input  logic              d_wr_req,
    input  logic [AWIDTH-1:0] d_wr_addr,
    input  logic [DWIDTH-1:0] d_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              fill_valid,
    output logic              fill_sel,
    output logic [AWIDTH-1:0] fill_addr,
    output logic [DWIDTH-1:0] fill_data,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              wr_ack
);
    localparam int CW     = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int PIPE_W = MEM_LATENCY - 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_BLOCK - 1);
    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic logic [AWIDTH-1:0] block_base(input logic [AWIDTH-1:0] addr);
        return addr & ~AWIDTH'(2 * WORDS_PER_BLOCK - 1);
    endfunction

    function automatic logic [AWIDTH-1:0] word_addr(input logic [AWIDTH-1:0] base,
                                                    input logic [CW-1:0]     idx);
        return base + AWIDTH'({idx, 1'b0});
    endfunction

    state_e              state_q;
    logic                owner_q;
    logic                last_fill_q;
    logic [AWIDTH-1:0]   base_q;
    logic [CW-1:0]       iss_q;
    logic [CW-1:0]       ret_q;
    logic [CW-1:0]       ret_d;
    logic [PIPE_W-1:0]   pipe_q;
    logic [PIPE_W-1:0]   pipe_d;
    logic                fill_valid_q;
    logic                fill_sel_q;
    logic [AWIDTH-1:0]   fill_addr_q;
    logic [AWIDTH-1:0]   fill_addr_d;
    logic                i_done_q;
    logic                d_done_q;
    logic                wr_ack_q;

    logic                grant_wr_s;
    logic                grant_fill_s;
    logic                grant_d_s;
    logic [AWIDTH-1:0]   grant_addr_s;
    logic                ret_valid_s;
    logic                last_ret_s;

    // Idle arbitration: stores first, then the fill side not served last time on a tie.
    always_comb begin
        grant_wr_s   = 1'b0;
        grant_fill_s = 1'b0;
        grant_d_s    = 1'b0;
        if (d_wr_req) begin
            grant_wr_s = 1'b1;
        end else if (i_miss && d_miss) begin
            grant_fill_s = 1'b1;
            grant_d_s    = (last_fill_q == SEL_I);
        end else if (d_miss) begin
            grant_fill_s = 1'b1;
            grant_d_s    = 1'b1;
        end else if (i_miss) begin
            grant_fill_s = 1'b1;
        end else begin
            grant_fill_s = 1'b0;
        end
        grant_addr_s = grant_d_s ? d_miss_addr : i_miss_addr;
    end

    // Return path: the top pipe bit flags that mem_rdata carries a fill word next cycle.
    always_comb begin
        pipe_d[0] = (state_q == ST_FILL);
        for (int i = 1; i < PIPE_W; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        ret_valid_s = pipe_q[PIPE_W-1];
        last_ret_s  = ret_valid_s && (ret_q == LAST_WORD);
        fill_addr_d = '0;
        ret_d       = ret_q;
        if (ret_valid_s) begin
            fill_addr_d = word_addr(base_q, ret_q);
            ret_d       = last_ret_s ? '0 : ret_q + 1'b1;
        end else begin
            fill_addr_d = '0;
        end
    end

    // Controller state, latency pipeline and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= SEL_I;
            last_fill_q  <= SEL_I;
            base_q       <= '0;
            iss_q        <= '0;
            ret_q        <= '0;
            pipe_q       <= '0;
            fill_valid_q <= 1'b0;
            fill_sel_q   <= 1'b0;
            fill_addr_q  <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
        end else begin
            pipe_q       <= pipe_d;
            ret_q        <= ret_d;
            fill_valid_q <= ret_valid_s;
            fill_sel_q   <= ret_valid_s & owner_q;
            fill_addr_q  <= fill_addr_d;
            i_done_q     <= last_ret_s & (owner_q == SEL_I);
            d_done_q     <= last_ret_s & (owner_q == SEL_D);
            wr_ack_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_wr_s) begin
                        state_q  <= ST_WRITE;
                        wr_ack_q <= 1'b1;
                    end else if (grant_fill_s) begin
                        state_q <= ST_FILL;
                        owner_q <= grant_d_s;
                        base_q  <= block_base(grant_addr_s);
                        iss_q   <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                end
                ST_FILL: begin
                    if (iss_q == LAST_WORD) begin
                        state_q <= ST_DRAIN;
                        iss_q   <= '0;
                    end else begin
                        iss_q   <= iss_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The done pulse is on the outputs this cycle, so the block is complete.
                    if (i_done_q || d_done_q) begin
                        state_q     <= ST_IDLE;
                        last_fill_q <= owner_q;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory port is a direct decode of the current state and issue counter.
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_wr_addr;
                mem_wdata = d_wr_data;
            end
            ST_FILL: begin
                mem_en   = 1'b1;
                mem_addr = word_addr(base_q, iss_q);
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    assign fill_valid  = fill_valid_q;
    assign fill_sel    = fill_sel_q;
    assign fill_addr   = fill_addr_q;
    assign fill_data   = fill_valid_q ? mem_rdata : '0;
    assign i_fill_done = i_done_q;
    assign d_fill_done = d_done_q;
    assign wr_ack      = wr_ack_q;

    cache_fill_ctrl_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .fill_valid  (fill_valid),
        .i_fill_done (i_fill_done),
        .d_fill_done (d_fill_done),
        .wr_ack      (wr_ack)
    );
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: a transaction-timeline model checked every
// cycle, plus hand-computed literal pins on key cycles.
module tb_cache_fill_ctrl;
    localparam int L = 4;
    localparam int W = 8;
    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_miss = 1'b0;
    logic [15:0] i_miss_addr = 16'h0000;
    logic        d_miss = 1'b0;
    logic [15:0] d_miss_addr = 16'h0000;
    logic        d_wr_req = 1'b0;
    logic [15:0] d_wr_addr = 16'h0000;
    logic [15:0] d_wr_data = 16'h0000;
    logic        mem_en, mem_wr, fill_valid, fill_sel, i_fill_done, d_fill_done, wr_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_addr, fill_data;

    cache_fill_ctrl dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .fill_valid(fill_valid), .fill_sel(fill_sel), .fill_addr(fill_addr), .fill_data(fill_data),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;

    // Memory: word[a] = a, returned L cycles after the read is issued.
    logic [15:0] mp [L];
    always @(posedge clk) begin
        mp[0] <= (mem_en && !mem_wr) ? mem_addr : 16'hDEAD;
        for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
    end
    assign mem_rdata = mp[L-1];

    // Expected-output timeline, indexed by cycle number.
    bit        e_men [N];
    bit        e_mwr [N];
    bit [15:0] e_maddr [N];
    bit [15:0] e_mwdata [N];
    bit        e_fv [N];
    bit        e_fsel [N];
    bit [15:0] e_faddr [N];
    bit        e_idone [N];
    bit        e_ddone [N];
    bit        e_wack [N];

    int   cyc = 0;
    int   free_c = 0;
    logic last_d = 1'b0;
    logic        m_sel;
    logic [15:0] m_base;
    assign m_sel  = d_miss && (!i_miss || !last_d);
    assign m_base = (m_sel ? d_miss_addr : i_miss_addr) & 16'hFFF0;

    // Model: when the controller is free, schedule a whole transaction's outputs.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (i > cyc) begin
                    e_men[i] <= 1'b0; e_mwr[i] <= 1'b0; e_fv[i] <= 1'b0;
                    e_idone[i] <= 1'b0; e_ddone[i] <= 1'b0; e_wack[i] <= 1'b0;
                end
            end
            free_c <= cyc + 1;
            last_d <= 1'b0;
        end else if (cyc >= free_c) begin
            if (d_wr_req) begin
                e_men[cyc+1]    <= 1'b1;
                e_mwr[cyc+1]    <= 1'b1;
                e_maddr[cyc+1]  <= d_wr_addr;
                e_mwdata[cyc+1] <= d_wr_data;
                e_wack[cyc+1]   <= 1'b1;
                free_c          <= cyc + 2;
            end else if (i_miss || d_miss) begin
                for (int k = 0; k < W; k++) begin
                    e_men[cyc+1+k]     <= 1'b1;
                    e_mwr[cyc+1+k]     <= 1'b0;
                    e_maddr[cyc+1+k]   <= m_base + 16'(2 * k);
                    e_fv[cyc+1+L+k]    <= 1'b1;
                    e_fsel[cyc+1+L+k]  <= m_sel;
                    e_faddr[cyc+1+L+k] <= m_base + 16'(2 * k);
                end
                if (m_sel) e_ddone[cyc+W+L] <= 1'b1;
                else       e_idone[cyc+W+L] <= 1'b1;
                free_c <= cyc + W + L + 1;
                last_d <= m_sel;
            end
        end
        cyc <= cyc + 1;
    end

    typedef struct {
        int          c;
        int          sig;
        logic [15:0] v;
        string       nm;
    } pin_t;
    pin_t pins[$];

    localparam int S_MEN = 0, S_MWR = 1, S_MADDR = 2, S_MWDATA = 3, S_FV = 4, S_FSEL = 5;
    localparam int S_FADDR = 6, S_FDATA = 7, S_IDONE = 8, S_DDONE = 9, S_WACK = 10;

    task automatic pin(input int c, input int sig, input logic [15:0] v, input string nm);
        pin_t p;
        p.c = c; p.sig = sig; p.v = v; p.nm = nm;
        pins.push_back(p);
    endtask

    function automatic logic [15:0] sig_val(input int id);
        case (id)
            S_MEN:    return {15'd0, mem_en};
            S_MWR:    return {15'd0, mem_wr};
            S_MADDR:  return mem_addr;
            S_MWDATA: return mem_wdata;
            S_FV:     return {15'd0, fill_valid};
            S_FSEL:   return {15'd0, fill_sel};
            S_FADDR:  return fill_addr;
            S_FDATA:  return fill_data;
            S_IDONE:  return {15'd0, i_fill_done};
            S_DDONE:  return {15'd0, d_fill_done};
            S_WACK:   return {15'd0, wr_ack};
            default:  return 16'hXXXX;
        endcase
    endfunction

    int   checks = 0;
    int   errors = 0;
    logic fin_req = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Compare process: model every cycle, then any literal pins for this cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
            chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
            chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
            chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
            chk("rst_fill_valid", {31'd0, fill_valid}, 32'd0);
            chk("rst_fill_sel", {31'd0, fill_sel}, 32'd0);
            chk("rst_fill_addr", {16'd0, fill_addr}, 32'd0);
            chk("rst_fill_data", {16'd0, fill_data}, 32'd0);
            chk("rst_dones", {30'd0, i_fill_done, d_fill_done}, 32'd0);
            chk("rst_wr_ack", {31'd0, wr_ack}, 32'd0);
        end else begin
            chk("mem_en", {31'd0, mem_en}, {31'd0, e_men[cyc]});
            if (e_men[cyc]) begin
                chk("mem_wr", {31'd0, mem_wr}, {31'd0, e_mwr[cyc]});
                chk("mem_addr", {16'd0, mem_addr}, {16'd0, e_maddr[cyc]});
                if (e_mwr[cyc]) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e_mwdata[cyc]});
            end
            chk("fill_valid", {31'd0, fill_valid}, {31'd0, e_fv[cyc]});
            if (e_fv[cyc]) begin
                chk("fill_sel", {31'd0, fill_sel}, {31'd0, e_fsel[cyc]});
                chk("fill_addr", {16'd0, fill_addr}, {16'd0, e_faddr[cyc]});
                chk("fill_data", {16'd0, fill_data}, {16'd0, e_faddr[cyc]});
            end
            chk("i_fill_done", {31'd0, i_fill_done}, {31'd0, e_idone[cyc]});
            chk("d_fill_done", {31'd0, d_fill_done}, {31'd0, e_ddone[cyc]});
            chk("wr_ack", {31'd0, wr_ack}, {31'd0, e_wack[cyc]});
        end
        for (int i = pins.size() - 1; i >= 0; i--) begin
            if (pins[i].c == cyc) begin
                chk(pins[i].nm, {16'd0, sig_val(pins[i].sig)}, {16'd0, pins[i].v});
                pins.delete(i);
            end
        end
        if (fin_req) chk("pins_unreached", pins.size(), 32'd0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int g;

    initial begin
        step(3);
        rst = 1'b1;
        step(1);

        // Single store.
        g = cyc;
        d_wr_req = 1'b1; d_wr_addr = 16'h0000; d_wr_data = 16'hABCD;
        pin(g+1, S_MEN, 16'd1, "st_mem_en");
        pin(g+1, S_MWR, 16'd1, "st_mem_wr");
        pin(g+1, S_MADDR, 16'h0000, "st_mem_addr");
        pin(g+1, S_MWDATA, 16'hABCD, "st_mem_wdata");
        pin(g+1, S_WACK, 16'd1, "st_wr_ack");
        pin(g+2, S_WACK, 16'd0, "st_wr_ack_once");
        pin(g+2, S_MEN, 16'd0, "st_idle_after");
        step(1);
        d_wr_req = 1'b0;
        step(2);

        // I-cache fill from a mid-block address.
        g = cyc;
        i_miss = 1'b1; i_miss_addr = 16'h1236;
        pin(g+1, S_MADDR, 16'h1230, "if_first_read");
        pin(g+8, S_MADDR, 16'h123E, "if_last_read");
        pin(g+9, S_MEN, 16'd0, "if_no_read_drain");
        pin(g+4, S_FV, 16'd0, "if_fv_before");
        pin(g+5, S_FV, 16'd1, "if_fv_first");
        pin(g+5, S_FADDR, 16'h1230, "if_faddr_first");
        pin(g+5, S_FDATA, 16'h1230, "if_fdata_first");
        pin(g+12, S_FADDR, 16'h123E, "if_faddr_last");
        pin(g+12, S_FSEL, 16'd0, "if_fsel");
        pin(g+11, S_IDONE, 16'd0, "if_done_early");
        pin(g+12, S_IDONE, 16'd1, "if_done");
        pin(g+13, S_FV, 16'd0, "if_fv_after");
        pin(g+13, S_IDONE, 16'd0, "if_done_once");
        step(13);
        i_miss = 1'b0;
        step(1);

        // Reset in the middle of a fill.
        g = cyc;
        i_miss = 1'b1; i_miss_addr = 16'h2004;
        pin(g+5, S_FV, 16'd1, "rf_fv_before_rst");
        step(6);
        rst = 1'b0;
        i_miss = 1'b0;
        pin(g+6, S_FV, 16'd0, "rf_fv_in_rst");
        pin(g+6, S_MEN, 16'd0, "rf_mem_en_in_rst");
        step(2);
        rst = 1'b1;
        pin(g+10, S_FV, 16'd0, "rf_no_fv_after");
        pin(g+12, S_IDONE, 16'd0, "rf_no_done_after");
        step(6);

        // Tie after reset: D first; repeat tie: I; then the remaining D.
        g = cyc;
        i_miss = 1'b1; i_miss_addr = 16'h3000;
        d_miss = 1'b1; d_miss_addr = 16'h4008;
        pin(g+5, S_FSEL, 16'd1, "tie1_sel_d");
        pin(g+5, S_FADDR, 16'h4000, "tie1_faddr");
        pin(g+12, S_DDONE, 16'd1, "tie1_d_done");
        pin(g+12, S_IDONE, 16'd0, "tie1_i_quiet");
        pin(g+18, S_FSEL, 16'd0, "tie2_sel_i");
        pin(g+18, S_FADDR, 16'h3000, "tie2_faddr");
        pin(g+25, S_IDONE, 16'd1, "tie2_i_done");
        pin(g+31, S_FSEL, 16'd1, "tie3_sel_d");
        pin(g+31, S_FADDR, 16'h5000, "tie3_faddr");
        pin(g+38, S_DDONE, 16'd1, "tie3_d_done");
        step(13);
        d_miss_addr = 16'h5000;
        step(13);
        i_miss = 1'b0;
        step(13);
        d_miss = 1'b0;
        step(1);

        // Store arriving during a D fill, with an I miss also pending.
        g = cyc;
        d_miss = 1'b1; d_miss_addr = 16'h6000;
        pin(g+9, S_MEN, 16'd0, "sw_no_write_drain");
        pin(g+12, S_DDONE, 16'd1, "sw_d_done");
        pin(g+13, S_MEN, 16'd0, "sw_idle");
        pin(g+14, S_MWR, 16'd1, "sw_mem_wr");
        pin(g+14, S_WACK, 16'd1, "sw_wr_ack");
        pin(g+14, S_MADDR, 16'h7770, "sw_mem_addr");
        pin(g+14, S_MWDATA, 16'h1357, "sw_mem_wdata");
        pin(g+20, S_FSEL, 16'd0, "sw_i_sel");
        pin(g+20, S_FADDR, 16'h8000, "sw_i_faddr");
        pin(g+27, S_IDONE, 16'd1, "sw_i_done");
        step(3);
        d_wr_req = 1'b1; d_wr_addr = 16'h7770; d_wr_data = 16'h1357;
        i_miss = 1'b1; i_miss_addr = 16'h8000;
        step(10);
        d_miss = 1'b0;
        step(1);
        d_wr_req = 1'b0;
        step(14);
        i_miss = 1'b0;
        step(1);

        // Top-of-memory block, requester drops the miss early.
        g = cyc;
        d_miss = 1'b1; d_miss_addr = 16'hFFFA;
        pin(g+1, S_MADDR, 16'hFFF0, "top_first_read");
        pin(g+8, S_MADDR, 16'hFFFE, "top_last_read");
        pin(g+9, S_MEN, 16'd0, "top_no_wrap_read");
        pin(g+5, S_FADDR, 16'hFFF0, "top_faddr_first");
        pin(g+12, S_FADDR, 16'hFFFE, "top_faddr_last");
        pin(g+12, S_FDATA, 16'hFFFE, "top_fdata_last");
        pin(g+12, S_DDONE, 16'd1, "top_d_done");
        step(3);
        d_miss = 1'b0;
        step(11);

        fin_req = 1'b1;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling controller between the instruction cache, the data cache and the single shared pipelined backing memory inside the memory system. Arbitrates I-cache block fills, D-cache block fills and D-side write-through stores onto one memory port, sequences each 8-word block fill and routes returned words to the requesting cache. Caches hold their miss/store request until the matching done/ack pulse and stall meanwhile.

## Interface
- AWIDTH, 16, byte address width
- DWIDTH, 16, word width
- WORDS_PER_BLOCK, 8, words per cache block (block = 16 bytes)
- MEM_LATENCY, 4, cycles from read issue to data on mem_rdata

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_miss  in  1  I-cache block fill request, held until i_fill_done
- i_miss_addr  in  AWIDTH  I-cache miss byte address
- d_miss  in  1  D-cache block fill request, held until d_fill_done
- d_miss_addr  in  AWIDTH  D-cache miss byte address
- d_wr_req  in  1  write-through store request, held until wr_ack
- d_wr_addr  in  AWIDTH  store byte address
- d_wr_data  in  DWIDTH  store data
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read (valid with mem_en)
- mem_addr  out  AWIDTH  memory byte address
- mem_wdata  out  DWIDTH  memory write data
- mem_rdata  in  DWIDTH  memory read data, valid MEM_LATENCY cycles after issue
- fill_valid  out  1  fill word present on fill_data/fill_addr
- fill_sel  out  1  0 = word for I-cache, 1 = for D-cache
- fill_addr  out  AWIDTH  byte address of current fill word
- fill_data  out  DWIDTH  fill word (mem_rdata passthrough)
- i_fill_done  out  1  one-cycle pulse, I-fill complete
- d_fill_done  out  1  one-cycle pulse, D-fill complete
- wr_ack  out  1  one-cycle pulse, store issued

## Operation
- States: IDLE, WRITE, FILL, DRAIN.
- IDLE arbitration, evaluated every IDLE cycle: d_wr_req wins over fills; between i_miss and d_miss, grant the side not served by the previous fill (last_fill flag, reset = I, so D wins first tie). Grant registers owner and base = miss_addr & ~(2*WORDS_PER_BLOCK-1); later changes to request address ignored.
- WRITE: one cycle, mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, wr_ack=1; return to IDLE.
- FILL: issue counter k = 0..WORDS_PER_BLOCK-1, one read per cycle: mem_en=1, mem_wr=0, mem_addr=base+2k. After k=WORDS_PER_BLOCK-1 go to DRAIN.
- Latency pipeline: MEM_LATENCY-deep valid shift register plus return counter; fill_valid=1 in the cycle data for issue k is on mem_rdata, fill_addr=base+2k, fill_sel=owner.
- DRAIN: no issue; on last return word assert owner's done pulse in same cycle as last fill_valid, update last_fill, go to IDLE.
- Stores and fills never interleave; d_wr_req arriving mid-fill waits until IDLE.
- Requester deasserting miss mid-fill: fill still completes and done still pulses.
- Address arithmetic modulo 2^AWIDTH (wrap at 16'hFFF0 block ok, no overflow handling needed).

## Timing
- Reset (rst=0, asynchronous): state IDLE, last_fill=I, counters and latency pipeline cleared; all outputs 0. Reset mid-fill discards in-flight returns: no fill_valid or done after release.
- Grant at edge E0 (IDLE with request). Fill: reads issued cycles 1..8 after E0; fill_valid cycles 1+L..8+L (L=MEM_LATENCY, i.e. 5..12); done pulse in cycle 12; IDLE in cycle 13, new grant sampled at end of cycle 13. Fill occupancy = WORDS_PER_BLOCK+MEM_LATENCY+1 cycles.
- Store: wr_ack and memory write in cycle 1 after E0; IDLE in cycle 2.
- Outputs are registered except fill_data (= mem_rdata) and mem_* driven from state/counters.
- mem_en never asserted in IDLE or DRAIN.

## Test plan
- Reset then d_wr_req, d_wr_addr=16'h0000, d_wr_data=16'hABCD -> cycle 1: mem_en=1, mem_wr=1, mem_addr=16'h0000, mem_wdata=16'hABCD, wr_ack=1 for exactly one cycle.
- i_miss with i_miss_addr=16'h1236, memory preloaded word[a]=a -> reads 16'h1230..16'h123E, eight fill_valid cycles 5..12 with fill_sel=0, fill_data=fill_addr, i_fill_done only in cycle 12.
- i_miss and d_miss asserted same cycle after reset -> D fill (fill_sel=1) first, d_fill_done, then I fill; repeat tie -> I served first next time.
- d_wr_req asserted during D fill -> no mem_wr until fill done; wr_ack in cycle after return to IDLE; store granted before still-pending i_miss.
- rst pulsed low at fill cycle 6 -> all outputs 0 immediately; after release no fill_valid/done; fresh request behaves as from reset.
- d_miss_addr=16'hFFFA -> fill addresses 16'hFFF0..16'hFFFE, no wrap beyond block, d_miss dropped at cycle 3 still yields eight words and d_fill_done.
